sign_extend: RTL and testbench
==============================

# sign_extend

Immediate sign-extension stage for the single-cycle processor datapath. Takes the 21-bit immediate field from the decoded instruction and widens it to a 32-bit two's-complement operand for the ALU and branch/address logic. The instruction MSB selects the immediate format. The result is registered, giving one clock of latency with a valid strobe.

## Interface
Parameters: none. Widths are fixed: 21-bit immediate in, 32-bit operand out.

Ports:
- clk  input  1  — system clock; all state updates on the rising edge.
- rst_n  input  1  — asynchronous, active-low reset.
- imm  input  21  — raw immediate field, imm[20:0].
- insmsb  input  1  — instruction MSB, the format select.
  - 1 = long (21-bit) immediate.
  - 0 = short (16-bit) immediate.
- in_valid  input  1  — imm and insmsb are valid this cycle.
- out  output  32  — registered sign-extended immediate.
- out_valid  output  1  — out was updated by the previous cycle's valid input.

## Operation
- Format select (combinational, inside the block):
  - insmsb = 1: ext = {{11{imm[20]}}, imm[20:0]}.
  - insmsb = 0: ext = {{16{imm[15]}}, imm[15:0]}. imm[20:16] are ignored.
- Register update on each rising clk edge with rst_n high:
  - in_valid = 1: out <= ext and out_valid <= 1.
  - in_valid = 0: out holds its previous value and out_valid <= 0.
- Pure two's-complement replication: no saturation, no overflow flag, no zero-extend mode.
- X or Z on imm while in_valid = 0 must not disturb out.

## Timing
- Latency: exactly 1 cycle. A sample at edge N appears on out and out_valid immediately after edge N.
- Throughput: one immediate per cycle. Back-to-back in_valid is accepted every cycle. There is no backpressure.
- Reset: asserting rst_n low immediately forces out = 32'h0000_0000 and out_valid = 0, regardless of clk.
- Reset mid-operation: any in-flight sample is discarded.
- Reset release: the first capture happens on the first rising edge with rst_n high and in_valid = 1.
- Select timing: insmsb is sampled together with imm at the same edge. Changing insmsb while in_valid = 0 has no effect on out.
- Boundary values:
  - imm[20] = 1 with insmsb = 1 yields upper 11 bits all ones.
  - imm[15] = 1 with insmsb = 0 yields upper 16 bits all ones.
  - The all-zero immediate yields 0 in both modes.

## Test plan
- Reset: hold rst_n = 0 for 100 ns with imm = 0 and insmsb = 0 -> out = 32'h0, out_valid = 0. Then assert rst_n low asynchronously mid-stream -> out clears without waiting for clk.
- Long, positive: imm = 21'h012345, insmsb = 1, in_valid = 1 -> after one edge, out = 32'h0001_2345 and out_valid = 1.
- Short, upper bits ignored: imm = 21'h012FF5, insmsb = 0 -> out = 32'h0000_2FF5.
- Long, negative:
  - imm = 21'h1FFFFF, insmsb = 1 -> out = 32'hFFFF_FFFF.
  - imm = 21'h100000, insmsb = 1 -> out = 32'hFFF0_0000.
- Short, boundary:
  - imm = 21'h008000, insmsb = 0 -> out = 32'hFFFF_8000.
  - imm = 21'h1F7FFF, insmsb = 0 -> out = 32'h0000_7FFF.
- Hold and streaming:
  - Drop in_valid and toggle imm/insmsb -> out holds its last value and out_valid = 0 from the next edge.
  - Drive three back-to-back valid samples -> three consecutive correct outputs, each one cycle delayed.

Source files
------------

// File: rtl/sign_extend.sv
// sign_extend
//   Widens the instruction immediate field to a 32-bit two's-complement
//   operand for the ALU and branch/address logic. The instruction MSB picks
//   the immediate format; the result is registered (one cycle latency) and
//   qualified by a valid strobe.
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   imm       in   21  raw immediate field imm[20:0]
//   insmsb    in   1   format select: 1 = long 21-bit, 0 = short 16-bit
//   in_valid  in   1   imm/insmsb valid this cycle
//   out       out  32  registered sign-extended immediate
//   out_valid out  1   out was loaded from the previous cycle's valid input
module sign_extend (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] imm,
  input  logic        insmsb,
  input  logic        in_valid,
  output logic [31:0] out,
  output logic        out_valid
);

  logic [31:0] ext;

  // Short format ignores imm[20:16] entirely.
  always_comb begin
    ext = '0;
    if (insmsb) begin
      ext = {{11{imm[20]}}, imm[20:0]};
    end else begin
      ext = {{16{imm[15]}}, imm[15:0]};
    end
  end

  // out only loads on a valid sample, so junk on imm while idle never reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= ext;
      end
    end
  end

endmodule

// File: tb/tb_sign_extend.sv
module tb_sign_extend;

  logic        clk;
  logic        rst_n;
  logic [20:0] imm;
  logic        insmsb;
  logic        in_valid;
  logic [31:0] out;
  logic        out_valid;

  int unsigned checks;
  int unsigned errors;

  sign_extend dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .imm      (imm),
    .insmsb   (insmsb),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, clock it in, sample 1 ns after the rising edge.
  task automatic step(input logic [20:0] i, input logic m, input logic v);
    @(negedge clk);
    imm      = i;
    insmsb   = m;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [20:0] i, input logic m,
                     input logic [31:0] exp);
    step(i, m, 1'b1);
    check32(tag, out, exp);
    check1({tag, "_v"}, out_valid, 1'b1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    imm      = '0;
    insmsb   = 1'b0;
    in_valid = 1'b0;
    #100;
    check32("reset_out", out, 32'h0000_0000);
    check1("reset_valid", out_valid, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release with no valid input: nothing captured.
    step(21'h012345, 1'b1, 1'b0);
    check32("idle_after_reset", out, 32'h0000_0000);
    check1("idle_after_reset_v", out_valid, 1'b0);

    vec("long_pos",     21'h012345, 1'b1, 32'h0001_2345);
    vec("short_ignhi",  21'h012FF5, 1'b0, 32'h0000_2FF5);
    vec("long_allones", 21'h1FFFFF, 1'b1, 32'hFFFF_FFFF);
    vec("long_minneg",  21'h100000, 1'b1, 32'hFFF0_0000);
    vec("long_maxpos",  21'h0FFFFF, 1'b1, 32'h000F_FFFF);
    vec("short_minneg", 21'h008000, 1'b0, 32'hFFFF_8000);
    vec("short_maxpos", 21'h1F7FFF, 1'b0, 32'h0000_7FFF);
    vec("long_zero",    21'h000000, 1'b1, 32'h0000_0000);
    vec("short_b15",    21'h1F8001, 1'b0, 32'hFFFF_8001);
    vec("short_zero",   21'h1F0000, 1'b0, 32'h0000_0000);
    vec("long_b20only", 21'h10FFFF, 1'b1, 32'hFFF0_FFFF);

    // Hold: in_valid low, imm junk and insmsb toggling.
    step(21'h012345, 1'b1, 1'b1);
    check32("pre_hold", out, 32'h0001_2345);
    step('x, 1'b0, 1'b0);
    check32("hold1", out, 32'h0001_2345);
    check1("hold1_v", out_valid, 1'b0);
    step(21'h1FFFFF, 1'b1, 1'b0);
    check32("hold2", out, 32'h0001_2345);
    check1("hold2_v", out_valid, 1'b0);
    step(21'h008000, 1'b0, 1'b0);
    check32("hold3", out, 32'h0001_2345);

    // Three back-to-back valid samples.
    vec("stream0", 21'h000ABC, 1'b1, 32'h0000_0ABC);
    vec("stream1", 21'h00F000, 1'b0, 32'hFFFF_F000);
    vec("stream2", 21'h1ABCDE, 1'b1, 32'hFFFA_BCDE);

    // Asynchronous reset mid-stream, away from any clock edge.
    @(negedge clk);
    imm      = 21'h054321;
    insmsb   = 1'b1;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check32("async_rst_out", out, 32'h0000_0000);
    check1("async_rst_v", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check32("rst_held_out", out, 32'h0000_0000);
    check1("rst_held_v", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    vec("post_rst", 21'h054321, 1'b1, 32'h0005_4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
